// File: rtl/vector_load_unit_if.sv
// Bus bundle for the vector load unit: control handshake, data-memory read port
// and the vector register-file write port.
interface vector_load_unit_if #(
    parameter int VEC_W  = 256,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [4:0]        rd_in;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              WriteEn;
    logic [4:0]        rd;
    logic [VEC_W-1:0]  InputData;

    // The load unit itself.
    modport slave (
        input  start, base_addr, rd_in, mem_rdata,
        output busy, done, err, mem_rd_en, mem_addr, WriteEn, rd, InputData
    );

    // Control stage plus memory: drives requests and read data, observes the rest.
    modport master (
        output start, base_addr, rd_in, mem_rdata,
        input  busy, done, err, mem_rd_en, mem_addr, WriteEn, rd, InputData
    );
endinterface

// File: rtl/vector_load_unit.sv
// Reads NWORDS sequential words from data memory, packs them LSW-first into one
// vector and writes that vector into the vector register file in a single cycle.
module vector_load_unit #(
    parameter int VEC_W  = 256,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input logic                clk,
    input logic                rst,
    vector_load_unit_if.slave  bus
);
    localparam int NWORDS = VEC_W / WORD_W;
    localparam int CNT_W  = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE, READ, LAST, WRITE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [4:0]        rd_lat_q;
    logic              cap_en_q;
    logic [CNT_W-1:0]  cap_idx_q;
    logic [VEC_W-1:0]  pack_q, pack_d;
    logic              err_q;
    logic [4:0]        rd_q;
    logic [VEC_W-1:0]  data_q;

    logic              busy_c;
    logic              rd_en_c;
    logic [ADDR_W-1:0] addr_c;
    logic              we_c;
    logic              accept;
    logic              rd_legal;

    // Destination codes 16..23 are exactly those with bits [4:3] == 2'b10.
    assign rd_legal = (bus.rd_in[4:3] == 2'b10);
    assign accept   = (state_q == IDLE) && bus.start && rd_legal;

    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        rd_en_c = 1'b0;
        addr_c  = '0;
        we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = READ;
            end
            READ: begin
                busy_c  = 1'b1;
                rd_en_c = 1'b1;
                addr_c  = base_q + ADDR_W'({cnt_q, 2'b00});
                if (cnt_q == CNT_W'(NWORDS - 1)) state_d = LAST;
            end
            LAST: begin
                busy_c  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                busy_c  = 1'b1;
                we_c    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pack buffer with the word returning this cycle merged in; the final word
    // arrives during LAST and goes straight into the write-data register.
    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < NWORDS; k++) begin
            if (cap_en_q && (cap_idx_q == CNT_W'(k))) begin
                pack_d[k*WORD_W +: WORD_W] = bus.mem_rdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the pack buffer is reset along with the control state because reset
    // must present a zero vector, not just an idle controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            rd_lat_q  <= '0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= '0;
            pack_q    <= '0;
            err_q     <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= (state_q == IDLE) && bus.start && !rd_legal;
            cap_en_q  <= rd_en_c;
            cap_idx_q <= cnt_q;
            pack_q    <= pack_d;
            if (accept) begin
                base_q   <= bus.base_addr & ~ADDR_W'(3);
                rd_lat_q <= bus.rd_in;
                cnt_q    <= '0;
            end else if (state_q == READ) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Write port outputs change only when a new vector is about to be written.
            if (state_q == LAST) begin
                rd_q   <= rd_lat_q;
                data_q <= pack_d;
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = we_c;
    assign bus.err       = err_q;
    assign bus.mem_rd_en = rd_en_c;
    assign bus.mem_addr  = addr_c;
    assign bus.WriteEn   = we_c;
    assign bus.rd        = rd_q;
    assign bus.InputData = data_q;
endmodule
